apb_req_master: RTL and testbench

Drives the APB side of the AXI-to-APB bridge. It takes one buffered request at a time from the request stream coming out of the bridge's channel FIFOs. It runs one complete APB3/APB4 transfer for that request: SETUP phase, then ACCESS phase with wait states and an optional timeout. It then returns read data and error status on a valid/ready response stream that feeds back toward the AXI response channels.

---
 rtl/apb_req_master.sv | 124 ++++++++++++
 tb/tb_apb_req_master.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_master.sv
// APB3/APB4 requester for the AXI-to-APB bridge. Runs one SETUP/ACCESS transfer
// per buffered request and returns read data and error status on a response stream.
`timescale 1ns/1ps
module apb_req_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_write_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
  input  logic [2:0]              req_prot_i,
  input  logic [ID_WIDTH-1:0]     req_id_i,

  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [DATA_WIDTH-1:0]   resp_rdata_o,
  output logic                    resp_err_o,
  output logic [ID_WIDTH-1:0]     resp_id_o,

  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  output logic [2:0]              pprot_o,
  input  logic                    pready_i,
  input  logic                    pslverr_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i
);

  localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Counter value held during the last permitted ACCESS cycle (first cycle holds 0).
  localparam int unsigned CNT_LAST  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] access_cnt;
  logic                 timeout_c;

  // ACCESS cycles already elapsed; expiry is flagged in the final allowed cycle.
  assign timeout_c = TIMEOUT_EN && (access_cnt == CNT_WIDTH'(CNT_LAST));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= IDLE;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
      resp_id_o    <= '0;
      psel_o       <= 1'b0;
      penable_o    <= 1'b0;
      pwrite_o     <= 1'b0;
      paddr_o      <= '0;
      pwdata_o     <= '0;
      pstrb_o      <= '0;
      pprot_o      <= '0;
      access_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            state       <= SETUP;
            req_ready_o <= 1'b0;
            psel_o      <= 1'b1;
            penable_o   <= 1'b0;
            paddr_o     <= req_addr_i;
            pwrite_o    <= req_write_i;
            pwdata_o    <= req_write_i ? req_wdata_i : '0;
            pstrb_o     <= req_write_i ? req_wstrb_i : '0;
            pprot_o     <= req_prot_i;
            resp_id_o   <= req_id_i;
          end
        end
        SETUP: begin
          state      <= ACCESS;
          penable_o  <= 1'b1;
          access_cnt <= '0;
        end
        ACCESS: begin
          // pready_i takes priority over an expiring timeout in the same cycle.
          if (pready_i || timeout_c) begin
            state        <= RESP;
            psel_o       <= 1'b0;
            penable_o    <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_err_o   <= pready_i ? pslverr_i : 1'b1;
            resp_rdata_o <= (pready_i && !pwrite_o) ? prdata_i : '0;
          end else if (access_cnt != CNT_MAX) begin
            access_cnt <= access_cnt + CNT_WIDTH'(1);
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            state        <= IDLE;
            resp_valid_o <= 1'b0;
            req_ready_o  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_master.sv
// Randomized scoreboard bench for apb_req_master with an APB completer model
// and a response monitor checking data, error, tag, latency and stability.
`timescale 1ns/1ps
module tb_apb_req_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = 4;
  localparam int          TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic          req_write_i;
  logic [DW-1:0] req_wdata_i;
  logic [SW-1:0] req_wstrb_i;
  logic [2:0]    req_prot_i;
  logic [IW-1:0] req_id_i;
  logic          resp_valid_o;
  logic          resp_ready_i;
  logic [DW-1:0] resp_rdata_o;
  logic          resp_err_o;
  logic [IW-1:0] resp_id_o;
  logic          psel_o, penable_o, pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic [SW-1:0] pstrb_o;
  logic [2:0]    pprot_o;
  logic          pready_i, pslverr_i;
  logic [DW-1:0] prdata_i;

  apb_req_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_write_i(req_write_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .req_prot_i(req_prot_i), .req_id_i(req_id_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_rdata_o(resp_rdata_o),
    .resp_err_o(resp_err_o), .resp_id_o(resp_id_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pprot_o(pprot_o),
    .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [2:0]    prot;
    logic [IW-1:0] id;
    int            waits;   // completer wait states before pready
    logic          slverr;
    logic [DW-1:0] rdata;
    int            hold;    // cycles the monitor withholds resp_ready
    int            acc;     // expected ACCESS cycles
    bit            abort;   // transfer killed by reset
  } txn_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic [IW-1:0] id;
    int            cyc;
    int            hold;
  } exp_t;

  txn_t slv_q[$];
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   resp_hs_cyc = -10;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: completer answers after waits+1 ACCESS cycles unless the
  // timeout budget of TO cycles runs out first.
  function automatic int access_len(input txn_t t);
    return (t.waits + 1 > TO) ? TO : t.waits + 1;
  endfunction

  function automatic exp_t model(input txn_t t, input int hs);
    exp_t e;
    bit   timed;
    timed   = (t.waits + 1 > TO);
    e.err   = timed ? 1'b1 : t.slverr;
    e.rdata = (timed || t.wr) ? '0 : t.rdata;
    e.id    = t.id;
    e.cyc   = hs + 2 + access_len(t);
    e.hold  = t.hold;
    return e;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.addr   = $urandom;
    t.wr     = 1'($urandom_range(0, 1));
    t.wdata  = $urandom;
    t.wstrb  = SW'($urandom);
    t.prot   = 3'($urandom);
    t.id     = IW'($urandom);
    t.waits  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 12)) : int'($urandom_range(0, 3));
    t.slverr = ($urandom_range(0, 3) == 0);
    t.rdata  = $urandom;
    t.hold   = int'($urandom_range(0, 3));
    t.acc    = 0;
    t.abort  = 1'b0;
    return t;
  endfunction

  // Present a request at the current negedge and wait (bounded) for acceptance.
  task automatic send(input txn_t t_in);
    txn_t t;
    int   waited;
    t = t_in;
    t.acc = access_len(t);
    req_valid_i = 1'b1;
    req_addr_i  = t.addr;
    req_write_i = t.wr;
    req_wdata_i = t.wdata;
    req_wstrb_i = t.wstrb;
    req_prot_i  = t.prot;
    req_id_i    = t.id;
    waited = 0;
    while (!req_ready_o && waited < 200) begin
      @(negedge clk_i);
      waited++;
    end
    if (!req_ready_o) begin
      check("req_accept_timeout", 0, 1);
      req_valid_i = 1'b0;
      return;
    end
    if (waited > 0) check("accept_after_resp", cyc, resp_hs_cyc + 1);
    sb_q.push_back(model(t, cyc));
    slv_q.push_back(t);
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !req_ready_o) && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 500) check("drain_timeout", 0, 1);
  endtask

  // APB completer: checks SETUP fields, stability and ACCESS length.
  initial begin
    txn_t          t;
    int            n;
    bit            stable;
    logic [DW-1:0] ewd;
    logic [SW-1:0] ews;
    pready_i = 1'b0;
    pslverr_i = 1'b0;
    prdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (psel_o && !penable_o) begin
        if (slv_q.size() == 0) begin
          check("unexpected_setup", 1, 0);
        end else begin
          t   = slv_q.pop_front();
          ewd = t.wr ? t.wdata : '0;
          ews = t.wr ? t.wstrb : '0;
          check("setup_fields", {paddr_o, pwrite_o, pwdata_o, pstrb_o, pprot_o},
                {t.addr, t.wr, ewd, ews, t.prot});
          pready_i  = 1'($urandom_range(0, 1));
          pslverr_i = 1'($urandom_range(0, 1));
          prdata_i  = $urandom;
          n = 0;
          stable = 1'b1;
          @(negedge clk_i);
          while (psel_o && penable_o && n < 64) begin
            n++;
            if (paddr_o !== t.addr || pwdata_o !== ewd || pstrb_o !== ews || pwrite_o !== t.wr)
              stable = 1'b0;
            pready_i  = (n == t.waits + 1);
            pslverr_i = pready_i ? t.slverr : 1'($urandom_range(0, 1));
            prdata_i  = pready_i ? t.rdata : $urandom;
            @(negedge clk_i);
          end
          if (!t.abort) begin
            check("access_cycles", n, t.acc);
            check("access_stable", stable, 1);
          end
        end
      end else begin
        pready_i  = 1'($urandom_range(0, 1));
        pslverr_i = 1'($urandom_range(0, 1));
        prdata_i  = $urandom;
      end
    end
  end

  // Response monitor with per-transaction backpressure.
  initial begin
    exp_t                 cur;
    bit                   held;
    int                   wait_n;
    logic [DW+IW:0]       snap;
    held = 1'b0;
    wait_n = 0;
    resp_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (resp_valid_o) begin
        if (!held) begin
          if (sb_q.size() == 0) begin
            check("unexpected_resp", 1, 0);
            resp_ready_i = 1'b1;
            continue;
          end
          cur    = sb_q.pop_front();
          held   = 1'b1;
          wait_n = 0;
          snap   = {resp_rdata_o, resp_err_o, resp_id_o};
          check("resp_latency", cyc, cur.cyc);
          check("resp_apb_idle", {psel_o, penable_o, req_ready_o}, 3'b000);
        end else begin
          check("resp_stable", {resp_rdata_o, resp_err_o, resp_id_o, req_ready_o, psel_o},
                {snap, 2'b00});
        end
        if (wait_n >= cur.hold) begin
          resp_ready_i = 1'b1;
          check("resp_rdata", resp_rdata_o, cur.rdata);
          check("resp_err", resp_err_o, cur.err);
          check("resp_id", resp_id_o, cur.id);
          resp_hs_cyc = cyc;
          held = 1'b0;
        end else begin
          resp_ready_i = 1'b0;
          wait_n++;
        end
      end else begin
        held = 1'b0;
        resp_ready_i = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    txn_t t, t2;
    int   n;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_write_i = 1'b0;
    req_wdata_i = '0;
    req_wstrb_i = '0;
    req_prot_i  = '0;
    req_id_i    = '0;
    rst_ni      = 1'b0;
    repeat (2) @(negedge clk_i);
    check("reset_req_ready", req_ready_o, 1);
    check("reset_outputs", {psel_o, penable_o, pwrite_o, resp_valid_o, resp_err_o, paddr_o,
                            pwdata_o, pstrb_o, pprot_o, resp_rdata_o, resp_id_o}, 0);
    rst_ni = 1'b1;

    // Zero-wait write
    t = rand_txn();
    t.addr = 32'h0000_1004; t.wr = 1'b1; t.wdata = 32'hDEAD_BEEF; t.wstrb = 4'hF;
    t.waits = 0; t.hold = 0;
    send(t); wait_drain();
    // Read with three wait states
    t = rand_txn();
    t.addr = 32'h20; t.wr = 1'b0; t.rdata = 32'h1234_5678; t.waits = 3; t.slverr = 1'b0;
    send(t); wait_drain();
    // Read with slave error and tag 0xA
    t = rand_txn();
    t.wr = 1'b0; t.slverr = 1'b1; t.id = 4'hA; t.waits = 1;
    send(t); wait_drain();
    // Timeout with pready never raised
    t = rand_txn();
    t.wr = 1'b0; t.waits = 100; t.slverr = 1'b0;
    send(t); wait_drain();
    // pready in the last permitted cycle: normal completion
    t = rand_txn();
    t.wr = 1'b0; t.waits = TO - 1; t.slverr = 1'b0;
    send(t); wait_drain();
    t = rand_txn();
    t.wr = 1'b1; t.waits = TO - 1; t.slverr = 1'b1;
    send(t); wait_drain();
    // Five cycles of response backpressure with a second request waiting
    t = rand_txn();
    t.waits = 0; t.hold = 5;
    send(t);
    t2 = rand_txn();
    t2.hold = 0;
    send(t2);
    wait_drain();

    for (int i = 0; i < 80; i++) begin
      t = rand_txn();
      send(t);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end
    wait_drain();

    // Reset during ACCESS: transfer is dropped without a response
    t = rand_txn();
    t.waits = 100; t.abort = 1'b1;
    send(t);
    n = 0;
    while (!(psel_o && penable_o) && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("reach_access", psel_o && penable_o, 1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    @(negedge clk_i);
    check("reset_mid_access", {psel_o, penable_o, resp_valid_o, req_ready_o}, 4'b0001);
    rst_ni = 1'b1;

    t = rand_txn();
    t.waits = 0;
    send(t); wait_drain();
    repeat (10) @(negedge clk_i);
    check("scoreboard_empty", sb_q.size(), 0);
    check("completer_queue_empty", slv_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
